// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/write-back. It drives the datapath controls from the current state
// and keeps a retired-instruction counter.
module mips_multicycle_control #(
  parameter int unsigned CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             ALUSrcA,
  output logic [3:0]       state,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
    logic       halt;
  } ctrl_t;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_c;
  logic [CNT_W-1:0] count_q;
  logic             retire_c;

  // Moore output table: control word for a given state.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RTYPEWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.pc_write_cond = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_HALT:     c.halt = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Next-state and retire decision; opcode only matters in DECODE/MEMADDR.
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_d = S_HALT;
            end else begin
              state_d  = S_FETCH;
              retire_c = 1'b1;
            end
          end
        endcase
      end
      S_MEMADDR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          // Opcode changed under us: abandon the instruction unretired.
          state_d = S_FETCH;
        end
      end
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_RTYPEWB;
      S_MEMWB, S_MEMWRITE, S_RTYPEWB, S_BRANCH, S_JUMP: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // State, registered control word and retire counter; reset wins over retire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
      if (retire_c) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Force every control low while reset is held so no PC/IR write can occur.
  always_comb begin
    ctrl_c = reset ? '0 : ctrl_q;
  end

  assign ALUOp       = ctrl_c.alu_op;
  assign ALUSrcB     = ctrl_c.alu_src_b;
  assign PCSource    = ctrl_c.pc_source;
  assign RegDst      = ctrl_c.reg_dst;
  assign MemtoReg    = ctrl_c.mem_to_reg;
  assign MemRead     = ctrl_c.mem_read;
  assign MemWrite    = ctrl_c.mem_write;
  assign IorD        = ctrl_c.i_or_d;
  assign RegWrite    = ctrl_c.reg_write;
  assign IRWrite     = ctrl_c.ir_write;
  assign PCWrite     = ctrl_c.pc_write;
  assign PCWriteCond = ctrl_c.pc_write_cond;
  assign ALUSrcA     = ctrl_c.alu_src_a;
  assign halt        = ctrl_c.halt;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: three instances cover the
// default build, the illegal-as-no-op build and a 3-bit retire counter.
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ILL   = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic [5:0] op0 = '0, op1 = '0, op2 = '0;

  logic [1:0]  aop0, sb0, pcs0, aop1, sb1, pcs1, aop2, sb2, pcs2;
  logic        rd0, m2r0, mr0, mw0, iod0, rw0, irw0, pcw0, pcwc0, sa0, h0;
  logic        rd1, m2r1, mr1, mw1, iod1, rw1, irw1, pcw1, pcwc1, sa1, h1;
  logic        rd2, m2r2, mr2, mw2, iod2, rw2, irw2, pcw2, pcwc2, sa2, h2;
  logic [3:0]  st0, st1, st2;
  logic [31:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  mips_multicycle_control dut0 (
    .clock(clock), .reset(rst0), .opcode(op0),
    .ALUOp(aop0), .ALUSrcB(sb0), .PCSource(pcs0),
    .RegDst(rd0), .MemtoReg(m2r0), .MemRead(mr0), .MemWrite(mw0),
    .IorD(iod0), .RegWrite(rw0), .IRWrite(irw0), .PCWrite(pcw0),
    .PCWriteCond(pcwc0), .ALUSrcA(sa0),
    .state(st0), .halt(h0), .instr_count(cnt0)
  );

  mips_multicycle_control #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut1 (
    .clock(clock), .reset(rst1), .opcode(op1),
    .ALUOp(aop1), .ALUSrcB(sb1), .PCSource(pcs1),
    .RegDst(rd1), .MemtoReg(m2r1), .MemRead(mr1), .MemWrite(mw1),
    .IorD(iod1), .RegWrite(rw1), .IRWrite(irw1), .PCWrite(pcw1),
    .PCWriteCond(pcwc1), .ALUSrcA(sa1),
    .state(st1), .halt(h1), .instr_count(cnt1)
  );

  mips_multicycle_control #(.CNT_W(3), .HALT_ON_ILLEGAL(1'b1)) dut2 (
    .clock(clock), .reset(rst2), .opcode(op2),
    .ALUOp(aop2), .ALUSrcB(sb2), .PCSource(pcs2),
    .RegDst(rd2), .MemtoReg(m2r2), .MemRead(mr2), .MemWrite(mw2),
    .IorD(iod2), .RegWrite(rw2), .IRWrite(irw2), .PCWrite(pcw2),
    .PCWriteCond(pcwc2), .ALUSrcA(sa2),
    .state(st2), .halt(h2), .instr_count(cnt2)
  );

  logic [16:0] ctl0, ctl1, ctl2;
  assign ctl0 = {aop0, sb0, pcs0, rd0, m2r0, mr0, mw0, iod0, rw0, irw0, pcw0, pcwc0, sa0, h0};
  assign ctl1 = {aop1, sb1, pcs1, rd1, m2r1, mr1, mw1, iod1, rw1, irw1, pcw1, pcwc1, sa1, h1};
  assign ctl2 = {aop2, sb2, pcs2, rd2, m2r2, mr2, mw2, iod2, rw2, irw2, pcw2, pcwc2, sa2, h2};

  int          sel = 0;
  logic [3:0]  obs_st;
  logic [16:0] obs_ctl;
  logic [31:0] obs_cnt;

  always_comb begin
    obs_st  = st0;
    obs_ctl = ctl0;
    obs_cnt = cnt0;
    if (sel == 1) begin
      obs_st = st1; obs_ctl = ctl1; obs_cnt = cnt1;
    end else if (sel == 2) begin
      obs_st = st2; obs_ctl = ctl2; obs_cnt = 32'(cnt2);
    end
  end

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_cyc   = 0;
  exp_t        sb_q[$];
  logic [31:0] exp_cnt  = '0;
  logic [31:0] cnt_mask = 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (dut%0d, t=%0t)", tag, got, want, sel, $time);
    end
  endtask

  // Expected control word per state, in the same bit order as ctlN.
  function automatic logic [16:0] exp_ctl(input logic [3:0] s);
    logic [1:0] aop, sb, pcs;
    logic rd, m2r, mr, mw, iod, rw, irw, pcw, pcwc, sa, h;
    {aop, sb, pcs} = 6'b0;
    {rd, m2r, mr, mw, iod, rw, irw, pcw, pcwc, sa, h} = 11'b0;
    case (s)
      4'd0:  begin mr = 1'b1; irw = 1'b1; pcw = 1'b1; sb = 2'b01; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  begin mr = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mw = 1'b1; iod = 1'b1; end
      4'd6:  begin sa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; pcwc = 1'b1; aop = 2'b01; pcs = 2'b01; end
      4'd9:  begin pcw = 1'b1; pcs = 2'b10; end
      4'd10: h = 1'b1;
      default: ;
    endcase
    return {aop, sb, pcs, rd, m2r, mr, mw, iod, rw, irw, pcw, pcwc, sa, h};
  endfunction

  // Pop one expectation per cycle and compare against the selected instance.
  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cyc++;
      check($sformatf("state@%0d", n_cyc), 64'(obs_st), 64'(e.st));
      check($sformatf("ctrl@%0d", n_cyc), 64'(obs_ctl), 64'(e.ctl));
      check($sformatf("count@%0d", n_cyc), 64'(obs_cnt), 64'(e.cnt));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_state(input logic [3:0] s);
    exp_t e;
    e.st  = s;
    e.ctl = exp_ctl(s);
    e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic push_reset();
    exp_t e;
    e.st  = 4'd0;
    e.ctl = '0;
    e.cnt = '0;
    sb_q.push_back(e);
  endtask

  task automatic set_rst(input logic v);
    case (sel)
      0: rst0 = v;
      1: rst1 = v;
      default: rst2 = v;
    endcase
  endtask

  task automatic set_op(input logic [5:0] op);
    case (sel)
      0: op0 = op;
      1: op1 = op;
      default: op2 = op;
    endcase
  endtask

  task automatic do_reset(input int n);
    set_rst(1'b1);
    exp_cnt = '0;
    repeat (n) push_reset();
    cycles(n);
    set_rst(1'b0);
  endtask

  // Push the expected state path for one instruction, then let it run.
  task automatic run_op(input logic [5:0] op);
    int  path[$];
    bit  retire;
    retire = 1'b1;
    case (op)
      OP_LW:    path = '{0, 1, 2, 3, 4};
      OP_SW:    path = '{0, 1, 2, 5};
      OP_RTYPE: path = '{0, 1, 6, 7};
      OP_BEQ:   path = '{0, 1, 8};
      OP_J:     path = '{0, 1, 9};
      default: begin
        path = '{0, 1};
        retire = (sel == 1);
      end
    endcase
    foreach (path[i]) push_state(4'(path[i]));
    set_op(op);
    cycles(path.size());
    if (retire) exp_cnt = (exp_cnt + 32'd1) & cnt_mask;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(posedge clock);
    #1;

    // Default build: reset, LW, mixed stream.
    sel = 0;
    do_reset(3);
    run_op(OP_LW);
    run_op(OP_SW);
    run_op(OP_RTYPE);
    run_op(OP_BEQ);
    run_op(OP_J);
    check("count_after_stream", 64'(cnt0), 64'd5);

    // Reset pulsed while an LW sits in MEMREAD.
    push_state(4'd0); push_state(4'd1); push_state(4'd2); push_state(4'd3);
    set_op(OP_LW);
    cycles(3);
    #6;
    rst0 = 1'b1;
    #1;
    check("midrst_state", 64'(st0), 64'd0);
    check("midrst_count", 64'(cnt0), 64'd0);
    check("midrst_regwrite", 64'(rw0), 64'd0);
    @(posedge clock);
    #1;
    do_reset(1);
    run_op(OP_BEQ);

    // Illegal opcode halts and stays halted regardless of opcode.
    run_op(OP_ILL);
    repeat (20) push_state(4'd10);
    set_op(OP_LW);
    cycles(20);

    // Illegal-as-no-op build.
    sel = 1;
    do_reset(3);
    run_op(OP_ILL);
    run_op(6'b000001);
    run_op(OP_LW);
    push_state(4'd0);
    cycles(1);
    check("noop_count", 64'(cnt1), 64'd3);

    // 3-bit counter wraps after 8 retires.
    sel = 2;
    cnt_mask = 32'h7;
    do_reset(2);
    repeat (9) run_op(OP_RTYPE);
    push_state(4'd0);
    cycles(1);
    check("wrap_count", 64'(cnt2), 64'd1);

    if (sb_q.size() != 0) check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control unit for the multicycle MIPS datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath control input from the current state and from the opcode returned by the datapath. The CPU top instantiates it in place of the constant control assignments. It also reports halt status and keeps an instruction-retire counter for the testbench.

## Interface
Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1: when 1, an unsupported opcode sends the FSM to HALT. When 0, it is retired as a no-op and the FSM returns to FETCH.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26] from the datapath.
- ALUOp  output  2  ALU class: 00 add, 01 sub (branch compare), 10 R-type funct.
- ALUSrcB  output  2  ALU B select: 00 B, 01 const 4, 10 sign-ext offset, 11 offset<<2.
- PCSource  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump address.
- RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA  output  1 each  datapath controls, active-high.
- state  output  4  current state encoding (debug).
- halt  output  1  high while in HALT.
- instr_count  output  CNT_W  number of retired instructions.

## Operation
- Opcodes: RTYPE 000000, J 000010, BEQ 000100, LW 100011, SW 101011. Any other value is illegal.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5.
  - EXECUTE=6, RTYPEWB=7, BRANCH=8, JUMP=9, HALT=10.
  - Encodings 11–15 are unused and recover to FETCH on the next edge.
- Outputs are decoded from state only. Signals not listed for a state are 0:
  - FETCH: MemRead, IRWrite, PCWrite; ALUSrcB=01.
  - DECODE: ALUSrcB=11 (branch target computed into ALUOut).
  - MEMADDR: ALUSrcA; ALUSrcB=10.
  - MEMREAD: MemRead, IorD.
  - MEMWB: RegWrite, MemtoReg.
  - MEMWRITE: MemWrite, IorD.
  - EXECUTE: ALUSrcA; ALUOp=10.
  - RTYPEWB: RegDst, RegWrite.
  - BRANCH: ALUSrcA, PCWriteCond; ALUOp=01, PCSource=01.
  - JUMP: PCWrite; PCSource=10.
  - HALT: all zero; halt=1.
- Transitions:
  - FETCH→DECODE unconditionally.
  - DECODE samples opcode and branches: LW/SW→MEMADDR, RTYPE→EXECUTE, BEQ→BRANCH, J→JUMP.
  - DECODE with an illegal opcode: →HALT if HALT_ON_ILLEGAL=1, else →FETCH and the instruction is retired.
  - MEMADDR→MEMREAD if the opcode is LW, →MEMWRITE if it is SW.
  - MEMREAD→MEMWB; EXECUTE→RTYPEWB.
  - MEMWB, MEMWRITE, RTYPEWB, BRANCH and JUMP all go to FETCH.
  - HALT→HALT until reset.
- opcode is used only in DECODE and MEMADDR. In every other state the input is ignored.
- instr_count increments by 1 on each edge that leaves a terminal state (MEMWB, MEMWRITE, RTYPEWB, BRANCH, JUMP), or on an illegal-no-op DECODE→FETCH edge. It wraps modulo 2^CNT_W without saturating.

## Timing
- Reset asserted: state=FETCH, instr_count=0, halt=0. All control outputs are forced to 0 combinationally, so there is no PC or IR write during reset.
- The first FETCH is the first rising edge after reset deasserts.
- Outputs change only after a clock edge or on reset assertion. Output paths from opcode are not combinational.
- Cycles per instruction: LW 5, SW 4, R-type 4, BEQ 3, J 3, illegal no-op 2.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately and instr_count clears. A partial instruction is not retired.
- Reset takes priority over the retire-count increment on the same edge.

## Test plan
- Reset: hold reset for 3 cycles, release. Required: all controls 0 during reset; next cycle state=0 with MemRead=IRWrite=PCWrite=1, ALUSrcB=01; instr_count=0.
- LW (opcode 100011): state sequence 0,1,2,3,4,0. MemRead+IorD asserted in state 3, RegWrite+MemtoReg in state 4. instr_count 0→1 after 5 cycles.
- Mixed stream SW, R-type, BEQ, J: state paths 0-1-2-5, 0-1-6-7, 0-1-8, 0-1-9. PCWriteCond=1 with PCSource=01 in state 8; PCWrite=1 with PCSource=10 in state 9. instr_count=4 after 14 cycles.
- Illegal opcode 111111 with HALT_ON_ILLEGAL=1: state 0→1→10; halt=1; all controls 0; state held for 20 cycles. With HALT_ON_ILLEGAL=0: state 0→1→0 and instr_count increments.
- Reset pulsed during MEMREAD of an LW: state returns to 0 asynchronously, instr_count=0, RegWrite never asserted.
- CNT_W=3: retire 9 R-type instructions. Required: instr_count wraps 7→0 and ends at 1.
